// File: rtl/count_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_window_ctrl
// Purpose  : Gated measurement-window controller for an external 3-digit BCD
//            event counter. Clears the counter, enables it for a programmed
//            number of cycles, then latches the count and a threshold
//            comparison. Supports single-shot and continuous operation.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, abort, cont  - window request, cancel, back-to-back mode
//            win_len [WIN_W]     - window length in cycles (captured at start)
//            thresh [12]         - packed BCD detection threshold
//            d2, d1, d0 [4]      - live counter digits
//            clr_cnt, cnt_en     - counter clear / count-enable
//            busy, done          - activity flag / one-cycle completion pulse
//            result [12], detect - latched count and threshold hit
//            win_cnt [8]         - completed-window counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module count_window_ctrl #(
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [WIN_W-1:0] win_len,
  input  logic [11:0]      thresh,
  input  logic [3:0]       d2,
  input  logic [3:0]       d1,
  input  logic [3:0]       d0,
  output logic             clr_cnt,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [11:0]      result,
  output logic             detect,
  output logic [7:0]       win_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam logic [WIN_W-1:0] LEN_ZERO = '0;
  localparam logic [WIN_W-1:0] LEN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,   state_d;
  logic [WIN_W-1:0] len_q,     len_d;
  logic [WIN_W-1:0] dcnt_q,    dcnt_d;
  logic [11:0]      result_q,  result_d;
  logic             detect_q,  detect_d;
  logic             done_q,    done_d;
  logic [7:0]       win_cnt_q, win_cnt_d;

  logic [11:0]      live_cnt;
  assign live_cnt = {d2, d1, d0};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      dcnt_q    <= '0;
      result_q  <= 12'h000;
      detect_q  <= 1'b0;
      done_q    <= 1'b0;
      win_cnt_q <= 8'd0;
    end else begin
      len_q     <= len_d;
      dcnt_q    <= dcnt_d;
      result_q  <= result_d;
      detect_q  <= detect_d;
      done_q    <= done_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  // Next-state logic; abort wins over every transition out of a busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (abort)                 state_d = S_IDLE;
        else if (len_q == LEN_ZERO) state_d = S_LATCH;
        else                       state_d = S_COUNT;
      end
      S_COUNT: begin
        // dcnt_q holds the number of enable cycles still owed, including this one.
        if (abort)                 state_d = S_IDLE;
        else if (dcnt_q == LEN_ONE) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (abort)     state_d = S_IDLE;
        else if (cont) state_d = S_CLEAR;
        else           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    len_d     = len_q;
    dcnt_d    = dcnt_q;
    result_d  = result_q;
    detect_d  = detect_q;
    done_d    = 1'b0;
    win_cnt_d = win_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) len_d = win_len;
      end
      S_CLEAR: begin
        if (!abort) dcnt_d = len_q;
      end
      S_COUNT: begin
        if (!abort) dcnt_d = dcnt_q - LEN_ONE;
      end
      S_LATCH: begin
        if (!abort) begin
          result_d  = live_cnt;
          // Packed BCD orders the same as binary, so a plain compare suffices.
          detect_d  = (live_cnt >= thresh);
          done_d    = 1'b1;
          win_cnt_d = win_cnt_q + 8'd1;
          if (cont) len_d = win_len;
        end
      end
      default: ;
    endcase
  end

  // Moore outputs
  always_comb begin
    clr_cnt = (state_q == S_CLEAR);
    cnt_en  = (state_q == S_COUNT);
    busy    = (state_q != S_IDLE);
  end

  assign done    = done_q;
  assign result  = result_q;
  assign detect  = detect_q;
  assign win_cnt = win_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_count_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_window_ctrl
// Purpose  : Directed bench for count_window_ctrl with a behavioural 3-digit
//            BCD event counter driven by the DUT's clr_cnt / cnt_en.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cont = 1'b0;
  logic [15:0] win_len = 16'd0;
  logic [11:0] thresh = 12'h000;
  logic        clr_cnt, cnt_en, busy, done, detect;
  logic [11:0] result;
  logic [7:0]  win_cnt;

  logic        ev = 1'b0;
  logic [11:0] ev_cnt = 12'h000;

  int errors = 0;
  int checks = 0;

  int en_cycles, clr_cycles, done_count, done_cyc0, done_cyc1;

  always #5 clk = ~clk;

  count_window_ctrl #(.WIN_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .cont    (cont),
    .win_len (win_len),
    .thresh  (thresh),
    .d2      (ev_cnt[11:8]),
    .d1      (ev_cnt[7:4]),
    .d0      (ev_cnt[3:0]),
    .clr_cnt (clr_cnt),
    .cnt_en  (cnt_en),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .detect  (detect),
    .win_cnt (win_cnt)
  );

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] u, t, h;
    u = v[3:0]; t = v[7:4]; h = v[11:8];
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = (h == 4'd9) ? 4'd0 : h + 4'd1;
      end else t = t + 4'd1;
    end else u = u + 4'd1;
    return {h, t, u};
  endfunction

  // Event counter model
  always_ff @(posedge clk) begin
    if (clr_cnt)          ev_cnt <= 12'h000;
    else if (cnt_en && ev) ev_cnt <= bcd_inc(ev_cnt);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues start in the current cycle (cycle 0) and observes cycles 1..max_cyc.
  // Feeds up to n_ev event pulses per window while cnt_en is high.
  task automatic run_win(input logic [15:0] len, input int n_ev, input int max_cyc,
                         input int abort_cyc);
    int ev_in_win;
    en_cycles = 0; clr_cycles = 0; done_count = 0; done_cyc0 = -1; done_cyc1 = -1;
    ev_in_win = 0;
    win_len = len;
    start = 1'b1;
    ev = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      step();
      if (cyc == 1) begin
        start = 1'b0;
        if (!cont) win_len = ~len;
      end
      abort = (cyc == abort_cyc);
      if (clr_cnt) begin
        clr_cycles++;
        ev_in_win = 0;
      end
      if (done) begin
        if (done_count == 0) done_cyc0 = cyc;
        else                 done_cyc1 = cyc;
        done_count++;
        cont = 1'b0;
      end
      if (cnt_en) begin
        en_cycles++;
        ev = (ev_in_win < n_ev);
        ev_in_win++;
      end else begin
        ev = 1'b0;
      end
    end
    abort = 1'b0;
    ev = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_clr",     {31'd0, clr_cnt}, 32'd0);
    check("rst_en",      {31'd0, cnt_en},  32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_result",  {20'd0, result},  32'h000);
    check("rst_detect",  {31'd0, detect},  32'd0);
    check("rst_wincnt",  {24'd0, win_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic window: len 5, 4 events, threshold 3
    thresh = 12'h003;
    run_win(16'd5, 4, 12, 0);
    check("w5_en_cycles", en_cycles,  32'd5);
    check("w5_clr",       clr_cycles, 32'd1);
    check("w5_done_cyc",  done_cyc0,  32'd8);
    check("w5_done_cnt",  done_count, 32'd1);
    check("w5_result",    {20'd0, result},  32'h004);
    check("w5_detect",    {31'd0, detect},  32'd1);
    check("w5_wincnt",    {24'd0, win_cnt}, 32'd1);
    check("w5_idle",      {31'd0, busy},    32'd0);

    // Zero-length window
    run_win(16'd0, 0, 6, 0);
    check("w0_en_cycles", en_cycles,  32'd0);
    check("w0_done_cyc",  done_cyc0,  32'd3);
    check("w0_result",    {20'd0, result},  32'h000);
    check("w0_detect",    {31'd0, detect},  32'd0);
    check("w0_wincnt",    {24'd0, win_cnt}, 32'd2);
    thresh = 12'h000;
    run_win(16'd0, 0, 6, 0);
    check("w0t0_detect",  {31'd0, detect},  32'd1);
    check("w0t0_wincnt",  {24'd0, win_cnt}, 32'd3);

    // Threshold boundary: 099 then 100 against 100
    thresh = 12'h100;
    run_win(16'd100, 99, 106, 0);
    check("t99_done_cyc", done_cyc0, 32'd103);
    check("t99_result",   {20'd0, result},  32'h099);
    check("t99_detect",   {31'd0, detect},  32'd0);
    run_win(16'd100, 100, 106, 0);
    check("t100_result",  {20'd0, result},  32'h100);
    check("t100_detect",  {31'd0, detect},  32'd1);
    check("t100_wincnt",  {24'd0, win_cnt}, 32'd5);

    // Continuous mode: two back-to-back windows of length 3
    cont = 1'b1;
    run_win(16'd3, 2, 16, 0);
    check("cont_done_cnt", done_count, 32'd2);
    check("cont_done0",    done_cyc0,  32'd6);
    check("cont_done1",    done_cyc1,  32'd11);
    check("cont_clr",      clr_cycles, 32'd2);
    check("cont_en",       en_cycles,  32'd6);
    check("cont_result",   {20'd0, result},  32'h002);
    check("cont_detect",   {31'd0, detect},  32'd0);
    check("cont_wincnt",   {24'd0, win_cnt}, 32'd7);
    check("cont_idle",     {31'd0, busy},    32'd0);

    // Abort in the third COUNT cycle
    run_win(16'd10, 5, 10, 4);
    check("abt_en",        en_cycles,  32'd3);
    check("abt_done_cnt",  done_count, 32'd0);
    check("abt_idle",      {31'd0, busy},    32'd0);
    check("abt_result",    {20'd0, result},  32'h002);
    check("abt_wincnt",    {24'd0, win_cnt}, 32'd7);

    // start together with abort in IDLE is refused
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("sa_idle", {31'd0, busy}, 32'd0);

    // Reset asserted mid-COUNT
    thresh = 12'h003;
    win_len = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("mid_in_count", {31'd0, cnt_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy",   {31'd0, busy},    32'd0);
    check("mrst_en",     {31'd0, cnt_en},  32'd0);
    check("mrst_result", {20'd0, result},  32'h000);
    check("mrst_wincnt", {24'd0, win_cnt}, 32'd0);
    step(); step();
    check("mrst_done",   {31'd0, done},    32'd0);
    rst_n = 1'b1;
    step();
    check("post_idle",   {31'd0, busy},    32'd0);
    run_win(16'd5, 3, 12, 0);
    check("post_done_cyc", done_cyc0, 32'd8);
    check("post_result",   {20'd0, result},  32'h003);
    check("post_detect",   {31'd0, detect},  32'd1);
    check("post_wincnt",   {24'd0, win_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
